dmem_port_ctrl: RTL and testbench
=================================

// Module: dmem_port_ctrl
// PURPOSE
//  Per-core load/store front end sitting directly upstream of one data_memory port (Control/DataAddr/DataIn/DataOut).
//  Buffers core requests in an in-order FIFO, issues them one at a time with the memory's 2-bit command encoding,
//  waits out read latency, returns read data over a valid/ready handshake. Range-checks addresses; counts faults.
// PARAMETERS
//  FIFO_DEPTH  4    request FIFO entries (power of 2, >=2)
//  RD_LAT      1    edges from ISSUE entry to valid DataOut (>=1)
//  MEM_DEPTH   256  legal addresses 0..MEM_DEPTH-1
// PORTS
//  Clock     in   1   single clock, all state updates on rising edge
//  Reset     in   1   synchronous, active-high
//  ReqValid  in   1   core request valid
//  ReqReady  out  1   FIFO can accept (= !full)
//  ReqWrite  in   1   1=store, 0=load
//  ReqAddr   in   16  word address
//  ReqData   in   16  store data
//  RspValid  out  1   load response valid
//  RspReady  in   1   core accepts response
//  RspData   out  16  load data
//  RspErr    out  1   load address out of range
//  ErrCnt    out  8   saturating count of out-of-range requests
//  Control   out  2   to memory: 2'd0 idle, 2'd2 read, 2'd3 write
//  DataAddr  out  16  to memory address
//  DataIn    out  16  to memory write data
//  DataOut   in   16  from memory read data
// BEHAVIOUR
//  Reset (sync, any state): FIFO emptied, FSM->IDLE, Control=0, DataAddr=0, DataIn=0, RspValid=0, RspData=0,
//   RspErr=0, ErrCnt=0, ReqReady=1 after the edge; in-flight read discarded, no late RspValid.
//  Accept: push on edge with ReqValid&&ReqReady. ReqReady=0 when full, even if a pop occurs same cycle.
//  All memory-side outputs registered; Control=0 in every state except ISSUE.
//  FSM: IDLE -> (FIFO non-empty) pop head, decode:
//   in-range store -> ISSUE: Control=3, DataAddr/DataIn=head, exactly 1 cycle -> IDLE.
//   in-range load  -> ISSUE: Control=2, 1 cycle -> WAIT (RD_LAT-1 cycles, skipped if RD_LAT=1);
//     DataOut captured into RspData at RD_LAT-th edge after ISSUE entry -> RESP.
//   out-of-range store (addr>=MEM_DEPTH) -> dropped, no Control pulse, ErrCnt+1, stay IDLE.
//   out-of-range load -> RESP directly, RspData=0, RspErr=1, ErrCnt+1.
//  RESP: RspValid=1, RspData/RspErr stable until edge with RspReady=1 -> IDLE, RspValid=0.
//   No new request issued while in RESP (one outstanding op; strict program order, RAW-safe).
//  Latency (empty FIFO, RspReady=1): load accept edge -> RspValid high RD_LAT+1 edges later;
//   store throughput 1 per 2 cycles.
//  ErrCnt saturates at 8'hFF, never wraps. FIFO pointers wrap modulo FIFO_DEPTH; full/empty via extra pointer bit.
//  DataAddr/DataIn hold last issued values outside ISSUE.
// TESTING
//  T1 store 16'd3 @3, then load @3 -> one cycle Control=3 DataAddr=3 DataIn=3; Control=2 once; RspData=3, RspErr=0,
//     RspValid 2 edges after load accept (RD_LAT=1).
//  T2 RspReady=0, 5 back-to-back loads @1..5 -> ReqReady falls after 4 accepted (+1 drained); responses in order 1..5.
//  T3 load @256 -> no Control=2 pulse, RspErr=1, RspData=0, ErrCnt=1; store @300 -> no Control=3, ErrCnt=2.
//  T4 RspReady held 0 for 5 cycles during RESP -> RspValid/RspData stable, Control stays 0, FIFO retains queued ops.
//  T5 Reset asserted during WAIT (RD_LAT=3) -> next edge all outputs at reset values; no RspValid afterwards.
//  T6 force ErrCnt path 260 out-of-range stores -> ErrCnt=8'hFF, memory never written.

Source files
------------

// File: rtl/dmem_port_ctrl.sv
// dmem_port_ctrl
//   Per-core load/store front end for one data_memory port. Core requests are
//   queued in an in-order FIFO and issued one at a time using the memory's
//   2-bit command encoding (0 idle, 2 read, 3 write). Read data is captured
//   RD_LAT edges after issue and returned over a valid/ready handshake.
//   Out-of-range addresses never reach the memory and bump a saturating
//   error counter.
//
// Ports
//   Clock, Reset          single clock, synchronous active-high reset
//   ReqValid/ReqReady     core request handshake (ReqReady = FIFO not full)
//   ReqWrite/ReqAddr/ReqData  request: 1=store, word address, store data
//   RspValid/RspReady     load response handshake
//   RspData/RspErr        load data, out-of-range flag
//   ErrCnt                saturating count of out-of-range requests
//   Control/DataAddr/DataIn  registered command, address, write data to memory
//   DataOut               read data from memory
module dmem_port_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1,
    parameter int MEM_DEPTH  = 256
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [15:0] ReqAddr,
    input  logic [15:0] ReqData,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [15:0] RspData,
    output logic        RspErr,
    output logic [7:0]  ErrCnt,
    output logic [1:0]  Control,
    output logic [15:0] DataAddr,
    output logic [15:0] DataIn,
    input  logic [15:0] DataOut
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } req_t;

    req_t        fifo_mem_q [FIFO_DEPTH];
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    state_t      state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]  control_q, control_d;
    logic [15:0] data_addr_q, data_addr_d;
    logic [15:0] data_in_q, data_in_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic fifo_empty, fifo_full, push, pop, head_oor;
    req_t head;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) &&
                        (wr_ptr_q[PW] != rd_ptr_q[PW]);
    assign push       = ReqValid && !fifo_full;
    assign head       = fifo_mem_q[rd_ptr_q[PW-1:0]];
    assign head_oor   = (32'(head.addr) >= 32'(MEM_DEPTH));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        control_d   = 2'd0;
        data_addr_d = data_addr_q;
        data_in_d   = data_in_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        pop         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_oor) begin
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                        // Out-of-range stores vanish; loads answer with an error.
                        if (!head.wr) begin
                            state_d     = S_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = 16'd0;
                            rsp_err_d   = 1'b1;
                        end
                    end else begin
                        state_d     = S_ISSUE;
                        control_d   = head.wr ? 2'd3 : 2'd2;
                        data_addr_d = head.addr;
                        if (head.wr) data_in_d = head.data;
                    end
                end
            end
            S_ISSUE: begin
                if (control_q == 2'd3) begin
                    state_d = S_IDLE;
                end else if (RD_LAT == 1) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = DataOut;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d    = S_WAIT;
                    wait_cnt_d = CW'(1);
                end
            end
            S_WAIT: begin
                // wait_cnt counts edges since ISSUE entry; capture on the RD_LAT-th.
                if (wait_cnt_q == CW'(RD_LAT - 1)) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = DataOut;
                    rsp_err_d   = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (RspReady) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wait_cnt_q  <= '0;
            control_q   <= 2'd0;
            data_addr_q <= 16'd0;
            data_in_q   <= 16'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'd0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wait_cnt_q  <= wait_cnt_d;
            control_q   <= control_d;
            data_addr_q <= data_addr_d;
            data_in_q   <= data_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // FIFO storage holds payload only; validity is tracked by the pointers.
    always_ff @(posedge Clock) begin
        if (push) fifo_mem_q[wr_ptr_q[PW-1:0]] <= '{wr: ReqWrite, addr: ReqAddr, data: ReqData};
    end

    assign ReqReady = !fifo_full;
    assign RspValid = rsp_valid_q;
    assign RspData  = rsp_data_q;
    assign RspErr   = rsp_err_q;
    assign ErrCnt   = err_cnt_q;
    assign Control  = control_q;
    assign DataAddr = data_addr_q;
    assign DataIn   = data_in_q;
endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Testbench for dmem_port_ctrl: a RD_LAT=1 instance backed by a small memory
// model, plus a RD_LAT=3 instance used for reset-during-wait and latency.
module tb_dmem_port_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RD_LAT = 1)
    logic        Reset, ReqValid, ReqReady, ReqWrite, RspValid, RspReady, RspErr;
    logic [15:0] ReqAddr, ReqData, RspData, DataAddr, DataIn, DataOut;
    logic [7:0]  ErrCnt;
    logic [1:0]  Control;

    // Second DUT (RD_LAT = 3)
    logic        b_reset, b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [15:0] b_req_addr, b_req_data, b_rsp_data, b_data_addr, b_data_in, b_data_out;
    logic [7:0]  b_err_cnt;
    logic [1:0]  b_control;

    dmem_port_ctrl #(.FIFO_DEPTH(4), .RD_LAT(1), .MEM_DEPTH(256)) u_dut (
        .Clock(clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspErr(RspErr),
        .ErrCnt(ErrCnt), .Control(Control), .DataAddr(DataAddr), .DataIn(DataIn),
        .DataOut(DataOut)
    );

    dmem_port_ctrl #(.FIFO_DEPTH(4), .RD_LAT(3), .MEM_DEPTH(256)) u_dut3 (
        .Clock(clk), .Reset(b_reset), .ReqValid(b_req_valid), .ReqReady(b_req_ready),
        .ReqWrite(b_req_write), .ReqAddr(b_req_addr), .ReqData(b_req_data),
        .RspValid(b_rsp_valid), .RspReady(b_rsp_ready), .RspData(b_rsp_data), .RspErr(b_rsp_err),
        .ErrCnt(b_err_cnt), .Control(b_control), .DataAddr(b_data_addr), .DataIn(b_data_in),
        .DataOut(b_data_out)
    );

    // Memory model: combinational read, write on the edge closing a write cycle.
    logic [15:0] mem [0:255];
    int wr_pulses = 0;
    int rd_pulses = 0;
    assign DataOut = mem[DataAddr[7:0]];
    always @(posedge clk) begin
        if (Control == 2'd3) begin
            wr_pulses <= wr_pulses + 1;
            if (DataAddr < 16'd256) mem[DataAddr[7:0]] <= DataIn;
        end
        if (Control == 2'd2) rd_pulses <= rd_pulses + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        ReqValid = 1'b1; ReqWrite = w; ReqAddr = a; ReqData = d;
        while (!ReqReady && n < 50) begin step(1); n++; end
        chk("req_ready_wait", ReqReady, 1);
        step(1);
        ReqValid = 1'b0;
    endtask

    task automatic get_rsp(input string nm, input logic [15:0] ed, input logic ee);
        int n = 0;
        RspReady = 1'b1;
        while (!RspValid && n < 50) begin step(1); n++; end
        chk({nm, "_valid"}, RspValid, 1);
        chk({nm, "_data"}, RspData, ed);
        chk({nm, "_err"}, RspErr, ee);
        step(1);
    endtask

    typedef struct {
        logic        w;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_data;
        logic        exp_err;
        logic [7:0]  exp_errcnt;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int wr0, rd0;

        vecs[0] = '{1'b1, 16'd0,      16'hA5A5, 16'h0000, 1'b0, 8'd0, 1, 0};
        vecs[1] = '{1'b1, 16'd255,    16'h1234, 16'h0000, 1'b0, 8'd0, 1, 0};
        vecs[2] = '{1'b0, 16'd255,    16'h0000, 16'h1234, 1'b0, 8'd0, 0, 1};
        vecs[3] = '{1'b0, 16'd0,      16'h0000, 16'hA5A5, 1'b0, 8'd0, 0, 1};
        vecs[4] = '{1'b0, 16'd256,    16'h0000, 16'h0000, 1'b1, 8'd1, 0, 0};
        vecs[5] = '{1'b1, 16'd300,    16'hFFFF, 16'h0000, 1'b0, 8'd2, 0, 0};
        vecs[6] = '{1'b0, 16'd3,      16'h0000, 16'h0003, 1'b0, 8'd2, 0, 1};
        vecs[7] = '{1'b1, 16'd3,      16'h8001, 16'h0000, 1'b0, 8'd2, 1, 0};
        vecs[8] = '{1'b0, 16'd3,      16'h0000, 16'h8001, 1'b0, 8'd2, 0, 1};
        vecs[9] = '{1'b0, 16'hFFFF,   16'h0000, 16'h0000, 1'b1, 8'd3, 0, 0};

        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = 16'h0; ReqData = 16'h0;
        RspReady = 1'b1;
        b_reset = 1'b1; b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 16'h0;
        b_req_data = 16'h0; b_rsp_ready = 1'b1; b_data_out = 16'hBEEF;
        step(3);
        chk("rst_ready", ReqReady, 1);
        chk("rst_control", Control, 0);
        chk("rst_rspvalid", RspValid, 0);
        chk("rst_errcnt", ErrCnt, 0);
        chk("rst_dataaddr", DataAddr, 0);
        Reset = 1'b0; b_reset = 1'b0;
        step(1);

        // T1: store 3 @3 then load @3, cycle exact
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 16'd3; ReqData = 16'd3;
        step(1);
        ReqValid = 1'b0;
        chk("t1_ctrl_after_accept", Control, 0);
        step(1);
        chk("t1_wr_ctrl", Control, 3);
        chk("t1_wr_addr", DataAddr, 3);
        chk("t1_wr_data", DataIn, 3);
        step(1);
        chk("t1_wr_one_cycle", Control, 0);
        chk("t1_mem3", mem[3], 3);
        rd0 = rd_pulses;
        RspReady = 1'b1;
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 16'd3;
        step(1);
        ReqValid = 1'b0;
        chk("t1_rsp_not_yet", RspValid, 0);
        step(1);
        chk("t1_rd_ctrl", Control, 2);
        step(1);
        chk("t1_rsp_valid", RspValid, 1);
        chk("t1_rsp_data", RspData, 3);
        chk("t1_rsp_err", RspErr, 0);
        chk("t1_rd_ctrl_off", Control, 0);
        chk("t1_rd_pulses", rd_pulses - rd0, 1);
        step(1);
        chk("t1_rsp_consumed", RspValid, 0);

        // Table of single transactions
        for (int i = 0; i < 10; i++) begin
            wr0 = wr_pulses; rd0 = rd_pulses;
            send(vecs[i].w, vecs[i].addr, vecs[i].data);
            if (vecs[i].w) step(3);
            else get_rsp($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_err);
            chk($sformatf("vec%0d_errcnt", i), ErrCnt, vecs[i].exp_errcnt);
            chk($sformatf("vec%0d_wr", i), wr_pulses - wr0, vecs[i].exp_wr);
            chk($sformatf("vec%0d_rd", i), rd_pulses - rd0, vecs[i].exp_rd);
        end

        // T2/T4: back-to-back loads with the response path stalled
        for (int i = 1; i <= 5; i++) begin
            send(1'b1, 16'(i), 16'h100 + 16'(i));
            step(3);
        end
        RspReady = 1'b0;
        for (int i = 1; i <= 5; i++) send(1'b0, 16'(i), 16'h0);
        chk("t2_ready_low", ReqReady, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t4_valid_hold", RspValid, 1);
            chk("t4_data_hold", RspData, 16'h101);
            chk("t4_ctrl_idle", Control, 0);
            step(1);
        end
        chk("t4_fifo_retained", ReqReady, 0);
        for (int i = 1; i <= 5; i++)
            get_rsp($sformatf("t2_rsp%0d", i), 16'h100 + 16'(i), 1'b0);

        // T5: reset during WAIT on the RD_LAT=3 instance
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 16'd5;
        step(1);
        b_req_addr = 16'd6;
        step(1);
        b_req_valid = 1'b0;
        chk("t5_issue", b_control, 2);
        step(1);
        chk("t5_wait_ctrl", b_control, 0);
        b_reset = 1'b1;
        step(1);
        b_reset = 1'b0;
        chk("t5_rst_ctrl", b_control, 0);
        chk("t5_rst_addr", b_data_addr, 0);
        chk("t5_rst_din", b_data_in, 0);
        chk("t5_rst_valid", b_rsp_valid, 0);
        chk("t5_rst_data", b_rsp_data, 0);
        chk("t5_rst_err", b_rsp_err, 0);
        chk("t5_rst_errcnt", b_err_cnt, 0);
        chk("t5_rst_ready", b_req_ready, 1);
        viol = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (b_rsp_valid !== 1'b0 || b_control !== 2'd0) viol++;
        end
        chk("t5_no_late_activity", viol, 0);
        // RD_LAT=3 latency: RspValid 4 edges after accept
        b_req_valid = 1'b1; b_req_addr = 16'd7;
        step(1);
        b_req_valid = 1'b0;
        step(3);
        chk("t5_lat_early", b_rsp_valid, 0);
        step(1);
        chk("t5_lat_valid", b_rsp_valid, 1);
        chk("t5_lat_data", b_rsp_data, 16'hBEEF);

        // T6: error counter saturation
        wr0 = wr_pulses;
        for (int i = 0; i < 260; i++) send(1'b1, 16'h8000 + 16'(i), 16'h5555);
        step(4);
        chk("t6_errcnt_sat", ErrCnt, 8'hFF);
        chk("t6_no_writes", wr_pulses - wr0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
